ram_arbiter: RTL

//  Two-requester arbiter for the single-port 8-bit-address data RAM. Port 0 is the processor

---
 rtl/ram_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Two-requester arbiter in front of the single-port data RAM.
//   Port 0 is the processor controller (store/load path) and port 1 is the
//   program/data loader (debug/DMA). One port owns the RAM at a time. Each
//   accepted access (req & gnt at an edge) becomes a registered one-cycle
//   cs_ram pulse. For a read, rvalid of the issuing port strobes one cycle
//   after that pulse, while rdata_ram carries the read data.
//
//   Build option: define ARB_RR_EN to make an IDLE tie round-robin against
//   the last owner. The first tie after reset goes to port 0. When the macro
//   is undefined, port 0 wins every tie.
//
// Ports
//   clk, rst              clock (rising edge); asynchronous active-high reset
//   req0/1, lock0/1       access request (held until accepted); keep ownership
//   wr0/1, addr0/1        1 = write / access address
//   wdata0/1              write data
//   gnt0/1                registered ownership, never both high
//   rvalid0/1             one-cycle read-data strobe, tagged by port
//   rdata                 read data broadcast to both ports (= rdata_ram)
//   cs_ram, wr_ram        registered RAM select pulse and write enable
//   addr_ram, wdata_ram   registered RAM address and write data
//   rdata_ram             RAM read data, valid the cycle after a read pulse
module ram_arbiter #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              cs_ram,
    output logic              wr_ram,
    output logic [ADDR_W-1:0] addr_ram,
    output logic [DATA_W-1:0] wdata_ram,
    input  logic [DATA_W-1:0] rdata_ram
);

    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

    localparam logic [8:0] MAX_LOCK_W = 9'(MAX_LOCK);

    state_t     state_q, state_d;
    logic [7:0] lock_cnt_q, lock_cnt_d;
    logic [8:0] cnt_inc;
    logic [1:0] acc;        // one-hot accept this cycle
    logic [1:0] rd_pend_q;  // read pulse on the RAM this cycle, by port
    logic [1:0] rvalid_q;
    logic       tie_to_1;

    assign acc[0]  = req0 & (state_q == OWN0);
    assign acc[1]  = req1 & (state_q == OWN1);
    // Widen by one bit so lock_cnt + 1 cannot wrap before the compare.
    assign cnt_inc = {1'b0, lock_cnt_q} + 9'd1;

`ifdef ARB_RR_EN
    // Reset value 1 sends the first tie to port 0.
    logic last_owner;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   last_owner <= 1'b1;
        else if (state_d == OWN0)  last_owner <= 1'b0;
        else if (state_d == OWN1)  last_owner <= 1'b1;
    end

    assign tie_to_1 = ~last_owner;
`else
    assign tie_to_1 = 1'b0;
`endif

    // A locked accept with budget left keeps ownership. Every other path
    // hands over to a waiting peer. If no peer is waiting, the owner stays
    // after an accept and the arbiter goes IDLE after a withdrawal.
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        unique case (state_q)
            IDLE: begin
                lock_cnt_d = '0;
                if (req0 && req1) state_d = tie_to_1 ? OWN1 : OWN0;
                else if (req0)    state_d = OWN0;
                else if (req1)    state_d = OWN1;
            end
            OWN0: begin
                if (acc[0] && lock0 && (cnt_inc < MAX_LOCK_W)) begin
                    lock_cnt_d = cnt_inc[7:0];
                end else begin
                    lock_cnt_d = '0;
                    if (req1)         state_d = OWN1;
                    else if (!acc[0]) state_d = IDLE;
                end
            end
            OWN1: begin
                if (acc[1] && lock1 && (cnt_inc < MAX_LOCK_W)) begin
                    lock_cnt_d = cnt_inc[7:0];
                end else begin
                    lock_cnt_d = '0;
                    if (req0)         state_d = OWN0;
                    else if (!acc[1]) state_d = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                lock_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            lock_cnt_q <= '0;
            cs_ram     <= 1'b0;
            wr_ram     <= 1'b0;
            addr_ram   <= '0;
            wdata_ram  <= '0;
            rd_pend_q  <= '0;
            rvalid_q   <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            cs_ram     <= |acc;
            wr_ram     <= (acc[0] & wr0) | (acc[1] & wr1);
            if (|acc) begin
                addr_ram  <= acc[1] ? addr1  : addr0;
                wdata_ram <= acc[1] ? wdata1 : wdata0;
            end
            // The read tag follows the RAM pulse by one cycle, so data that
            // returns after a hand-over still reaches the issuing port.
            rd_pend_q  <= acc & ~{wr1, wr0};
            rvalid_q   <= rd_pend_q;
        end
    end

    assign gnt0    = (state_q == OWN0);
    assign gnt1    = (state_q == OWN1);
    assign rvalid0 = rvalid_q[0];
    assign rvalid1 = rvalid_q[1];
    assign rdata   = rdata_ram;

endmodule
